// File: rtl/ddmtd_lock_detect.sv
// Lock detector for the DDMTD phase loop: windowed |err| with hysteresis and consecutive-sample counts.
// Latency: a valid sample in cycle N updates state, err_abs and event pulses in cycle N+1.
// Backpressure: none; samples are consumed every cycle they are presented, and ena=0 freezes everything.
//
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   ena                : global enable; 0 freezes all state, pulses read 0
//   phase_valid/err    : beat-domain phase-error strobe and signed error
//   clear_stats        : synchronous clear of slip_count and timeout_flag
//   locked/lock_state  : lock indication and raw state (IDLE=0 ACQUIRE=1 LOCKED=2 HOLD=3)
//   lock_event/unlock_event : one-cycle pulses on lock gain / loss
//   err_abs            : |phase_err| of the last accepted sample
//   slip_count         : saturating lock-loss counter
//   timeout_flag       : sticky starvation indication
module ddmtd_lock_detect #(
    parameter int ERR_W       = 16,
    parameter int LOCK_THR    = 64,
    parameter int UNLOCK_THR  = 256,
    parameter int LOCK_CNT    = 16,
    parameter int UNLOCK_CNT  = 4,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             phase_valid,
    input  logic [ERR_W-1:0] phase_err,
    input  logic             clear_stats,
    output logic             locked,
    output logic [1:0]       lock_state,
    output logic             lock_event,
    output logic             unlock_event,
    output logic [ERR_W-1:0] err_abs,
    output logic [7:0]       slip_count,
    output logic             timeout_flag
);

    localparam int ABS_W = ERR_W + 1;
    localparam int IN_W  = $clog2(LOCK_CNT + 1);
    localparam int OUT_W = $clog2(UNLOCK_CNT + 1);
    localparam int ST_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [ABS_W-1:0] LOCK_T   = ABS_W'(LOCK_THR);
    localparam logic [ABS_W-1:0] UNLOCK_T = ABS_W'(UNLOCK_THR);
    // Counter values at which the *current* sample completes the run.
    localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(LOCK_CNT - 1);
    localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(UNLOCK_CNT - 1);
    localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACQ    = 2'd1,
        S_LOCKED = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t           state_q;
    logic [IN_W-1:0]  in_cnt_q;
    logic [OUT_W-1:0] out_cnt_q;
    logic [ST_W-1:0]  starve_q;
    logic [ERR_W-1:0] err_abs_q;
    logic [7:0]       slip_count_q;
    logic             timeout_flag_q;
    logic             lock_event_q;
    logic             unlock_event_q;

    // Magnitude is taken one bit wider so the most negative input is exact.
    logic [ABS_W-1:0] err_ext;
    logic [ABS_W-1:0] err_mag;
    logic             in_win;
    logic             out_win;
    logic [7:0]       slip_inc;

    always_comb begin
        err_ext  = {phase_err[ERR_W-1], phase_err};
        err_mag  = phase_err[ERR_W-1] ? ((~err_ext) + ABS_W'(1)) : err_ext;
        in_win   = (err_mag <= LOCK_T);
        out_win  = (err_mag > UNLOCK_T);
        slip_inc = (slip_count_q == 8'hFF) ? 8'hFF : (slip_count_q + 8'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            in_cnt_q       <= '0;
            out_cnt_q      <= '0;
            starve_q       <= '0;
            err_abs_q      <= '0;
            slip_count_q   <= '0;
            timeout_flag_q <= 1'b0;
            lock_event_q   <= 1'b0;
            unlock_event_q <= 1'b0;
        end else begin
            lock_event_q   <= 1'b0;
            unlock_event_q <= 1'b0;
            if (ena) begin
                if (phase_valid) begin
                    err_abs_q <= err_mag[ERR_W-1:0];
                    starve_q  <= '0;
                    case (state_q)
                        S_IDLE: begin
                            state_q  <= S_ACQ;
                            in_cnt_q <= in_win ? IN_W'(1) : '0;
                        end
                        S_ACQ: begin
                            if (!in_win) begin
                                in_cnt_q <= '0;
                            end else if (in_cnt_q >= IN_LAST) begin
                                state_q      <= S_LOCKED;
                                lock_event_q <= 1'b1;
                                in_cnt_q     <= '0;
                            end else begin
                                in_cnt_q <= in_cnt_q + IN_W'(1);
                            end
                        end
                        S_LOCKED: begin
                            if (out_win) begin
                                if (UNLOCK_CNT == 1) begin
                                    state_q        <= S_ACQ;
                                    in_cnt_q       <= '0;
                                    out_cnt_q      <= '0;
                                    unlock_event_q <= 1'b1;
                                    slip_count_q   <= slip_inc;
                                end else begin
                                    state_q   <= S_HOLD;
                                    out_cnt_q <= OUT_W'(1);
                                end
                            end
                        end
                        default: begin // S_HOLD
                            if (!out_win) begin
                                // Hysteresis band and in-window samples both restore lock.
                                state_q   <= S_LOCKED;
                                out_cnt_q <= '0;
                            end else if (out_cnt_q >= OUT_LAST) begin
                                state_q        <= S_ACQ;
                                in_cnt_q       <= '0;
                                out_cnt_q      <= '0;
                                unlock_event_q <= 1'b1;
                                slip_count_q   <= slip_inc;
                            end else begin
                                out_cnt_q <= out_cnt_q + OUT_W'(1);
                            end
                        end
                    endcase
                end else if (state_q != S_IDLE) begin
                    // A sample arriving on the expiry cycle takes the branch above instead.
                    if (starve_q >= ST_LAST) begin
                        state_q        <= S_IDLE;
                        in_cnt_q       <= '0;
                        out_cnt_q      <= '0;
                        starve_q       <= '0;
                        timeout_flag_q <= 1'b1;
                        if (state_q == S_LOCKED || state_q == S_HOLD) begin
                            unlock_event_q <= 1'b1;
                            slip_count_q   <= slip_inc;
                        end
                    end else begin
                        starve_q <= starve_q + ST_W'(1);
                    end
                end
                // Last assignment wins over a same-cycle slip increment or timeout set.
                if (clear_stats) begin
                    slip_count_q   <= '0;
                    timeout_flag_q <= 1'b0;
                end
            end
        end
    end

    assign locked       = state_q[1];
    assign lock_state   = state_q;
    assign lock_event   = lock_event_q;
    assign unlock_event = unlock_event_q;
    assign err_abs      = err_abs_q;
    assign slip_count   = slip_count_q;
    assign timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_ddmtd_lock_detect.sv
// Bench for ddmtd_lock_detect: table-driven vectors, hand sequences for multi-cycle corners,
// and randomized traffic checked every cycle against a behavioural reference model.
// The starvation timeout is shortened so the whole run stays small.
module tb_ddmtd_lock_detect;

    localparam int ERR_W = 16;
    localparam int LTHR  = 64;
    localparam int UTHR  = 256;
    localparam int LCNT  = 16;
    localparam int UCNT  = 4;
    localparam int TMO   = 1000;

    localparam int ST_IDLE   = 0;
    localparam int ST_ACQ    = 1;
    localparam int ST_LOCKED = 2;
    localparam int ST_HOLD   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic             phase_valid;
    logic [ERR_W-1:0] phase_err;
    logic             clear_stats;
    logic             locked;
    logic [1:0]       lock_state;
    logic             lock_event;
    logic             unlock_event;
    logic [ERR_W-1:0] err_abs;
    logic [7:0]       slip_count;
    logic             timeout_flag;

    ddmtd_lock_detect #(
        .ERR_W(ERR_W), .LOCK_THR(LTHR), .UNLOCK_THR(UTHR),
        .LOCK_CNT(LCNT), .UNLOCK_CNT(UCNT), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .phase_valid(phase_valid),
        .phase_err(phase_err), .clear_stats(clear_stats),
        .locked(locked), .lock_state(lock_state), .lock_event(lock_event),
        .unlock_event(unlock_event), .err_abs(err_abs),
        .slip_count(slip_count), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: run lengths of in-window / out-of-window samples and idle time.
    int m_state, m_in_run, m_out_run, m_idle, m_abs, m_slip;
    bit m_tmo, m_lev, m_uev;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = ST_IDLE; m_in_run = 0; m_out_run = 0; m_idle = 0;
        m_abs = 0; m_slip = 0; m_tmo = 0; m_lev = 0; m_uev = 0;
    endtask

    task automatic model_slip();
        m_uev = 1;
        if (m_slip < 255) m_slip = m_slip + 1;
    endtask

    task automatic model(input bit en, input bit vl, input int e, input bit cl);
        int  a;
        bit  inw, outw;
        m_lev = 0;
        m_uev = 0;
        if (!en) return;
        if (vl) begin
            a = (e < 0) ? -e : e;
            m_abs = a;
            inw  = (a <= LTHR);
            outw = (a > UTHR);
            m_idle = 0;
            if (m_state == ST_IDLE) begin
                m_state  = ST_ACQ;
                m_in_run = inw ? 1 : 0;
            end else if (m_state == ST_ACQ) begin
                m_in_run = inw ? m_in_run + 1 : 0;
                if (m_in_run == LCNT) begin
                    m_state = ST_LOCKED; m_lev = 1; m_in_run = 0;
                end
            end else begin
                m_out_run = outw ? m_out_run + 1 : 0;
                if (m_out_run == UCNT) begin
                    m_state = ST_ACQ; m_in_run = 0; m_out_run = 0;
                    model_slip();
                end else begin
                    m_state = (m_out_run > 0) ? ST_HOLD : ST_LOCKED;
                end
            end
        end else if (m_state != ST_IDLE) begin
            m_idle = m_idle + 1;
            if (m_idle == TMO) begin
                if (m_state == ST_LOCKED || m_state == ST_HOLD) model_slip();
                m_state = ST_IDLE; m_in_run = 0; m_out_run = 0; m_idle = 0;
                m_tmo = 1;
            end
        end
        if (cl) begin
            m_slip = 0;
            m_tmo  = 0;
        end
    endtask

    task automatic check_model();
        chk("model_state",   int'(lock_state),   m_state);
        chk("model_locked",  int'(locked),       (m_state >= ST_LOCKED) ? 1 : 0);
        chk("model_lock_ev", int'(lock_event),   int'(m_lev));
        chk("model_unl_ev",  int'(unlock_event), int'(m_uev));
        chk("model_err_abs", int'(err_abs),      m_abs);
        chk("model_slip",    int'(slip_count),   m_slip);
        chk("model_timeout", int'(timeout_flag), int'(m_tmo));
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs checked 1 unit after the next one.
    task automatic step(input bit en, input bit vl, input int e, input bit cl);
        ena = en; phase_valid = vl; phase_err = ERR_W'(e); clear_stats = cl;
        model(en, vl, e, cl);
        @(posedge clk);
        #1;
        cyc++;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_locked"},  int'(locked),       0);
        chk({tag, "_state"},   int'(lock_state),   0);
        chk({tag, "_lock_ev"}, int'(lock_event),   0);
        chk({tag, "_unl_ev"},  int'(unlock_event), 0);
        chk({tag, "_err_abs"}, int'(err_abs),      0);
        chk({tag, "_slip"},    int'(slip_count),   0);
        chk({tag, "_timeout"}, int'(timeout_flag), 0);
    endtask

    typedef struct {
        int gap;
        bit en; bit vl; int err; bit cl;
        int st; bit lk; bit lev; bit uev; int abs_v; int slip; bit tmo;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int gap, input bit en, input bit vl, input int err, input bit cl,
                       input int st, input bit lk, input bit lev, input bit uev,
                       input int abs_v, input int slip, input bit tmo);
        vec_t v;
        v.gap = gap; v.en = en; v.vl = vl; v.err = err; v.cl = cl;
        v.st = st; v.lk = lk; v.lev = lev; v.uev = uev; v.abs_v = abs_v; v.slip = slip; v.tmo = tmo;
        tbl.push_back(v);
    endtask

    function automatic int rnd_err(input int pin);
        int r;
        int s;
        r = int'($urandom_range(0, 99));
        s = ($urandom_range(0, 1) == 1) ? 1 : -1;
        if (r < pin)      return int'($urandom_range(0, 2 * LTHR)) - LTHR;
        else if (r < 90)  return s * int'($urandom_range(LTHR + 1, UTHR));
        else if (r < 98)  return s * int'($urandom_range(UTHR + 1, 32767));
        else              return (s > 0) ? 32767 : -32768;
    endfunction

    initial begin
        // 16 samples of +10, eight cycles apart: lock on the 16th.
        for (int i = 0; i < 16; i++)
            add(7, 1, 1, 10, 0, (i == 15) ? 2 : 1, i == 15, i == 15, 0, 10, 0, 0);
        add(0, 1, 0, 0,      0, 2, 1, 0, 0, 10,    0, 0);  // lock_event lasts one cycle
        add(3, 1, 1, 100,    0, 2, 1, 0, 0, 100,   0, 0);  // hysteresis band keeps lock
        add(3, 1, 1, -32768, 0, 3, 1, 0, 0, 32768, 0, 0);  // most negative is out-of-window
        add(3, 1, 1, 5,      0, 2, 1, 0, 0, 5,     0, 0);
        add(3, 1, 1, 300,    0, 3, 1, 0, 0, 300,   0, 0);
        add(3, 1, 1, 300,    0, 3, 1, 0, 0, 300,   0, 0);
        add(3, 1, 1, 100,    0, 2, 1, 0, 0, 100,   0, 0);
        add(3, 1, 1, 300,    0, 3, 1, 0, 0, 300,   0, 0);
        add(3, 1, 1, 300,    0, 3, 1, 0, 0, 300,   0, 0);
        add(3, 1, 1, -300,   0, 3, 1, 0, 0, 300,   0, 0);
        add(3, 1, 1, 300,    0, 1, 0, 0, 1, 300,   1, 0);  // 4th consecutive: slip
        add(0, 1, 0, 0,      0, 1, 0, 0, 0, 300,   1, 0);
        for (int i = 0; i < 20; i++)                       // ena=0 freezes everything
            add(0, 0, 1, 10, 0, 1, 0, 0, 0, 300, 1, 0);

        rst = 1'b1; ena = 1'b0; phase_valid = 1'b0; phase_err = '0; clear_stats = 1'b0;
        model_reset();
        #3;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (tbl[i]) begin
            idle(tbl[i].gap);
            step(tbl[i].en, tbl[i].vl, tbl[i].err, tbl[i].cl);
            chk("vec_state",   int'(lock_state),   tbl[i].st);
            chk("vec_locked",  int'(locked),       int'(tbl[i].lk));
            chk("vec_lock_ev", int'(lock_event),   int'(tbl[i].lev));
            chk("vec_unl_ev",  int'(unlock_event), int'(tbl[i].uev));
            chk("vec_err_abs", int'(err_abs),      tbl[i].abs_v);
            chk("vec_slip",    int'(slip_count),   tbl[i].slip);
            chk("vec_timeout", int'(timeout_flag), int'(tbl[i].tmo));
        end

        // Acquisition restart: 15 in-window, one hysteresis-band sample, then a full run.
        for (int i = 0; i < 15; i++) begin step(1, 1, -50, 0); idle(2); end
        step(1, 1, 100, 0);
        chk("restart_after_100", int'(lock_state), ST_ACQ);
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 5, 0);
            if (i == 14) chk("restart_15th", int'(lock_state), ST_ACQ);
        end
        chk("restart_lock_state", int'(lock_state), ST_LOCKED);
        chk("restart_lock_event", int'(lock_event), 1);

        // Starvation from LOCKED.
        idle(TMO - 1);
        chk("starve_pre_state", int'(lock_state), ST_LOCKED);
        idle(1);
        chk("starve_state",   int'(lock_state),   ST_IDLE);
        chk("starve_unl_ev",  int'(unlock_event), 1);
        chk("starve_timeout", int'(timeout_flag), 1);
        chk("starve_slip",    int'(slip_count),   2);
        step(1, 0, 0, 1);
        chk("clear_slip",    int'(slip_count),   0);
        chk("clear_timeout", int'(timeout_flag), 0);

        // A sample on the expiry cycle prevents the timeout.
        for (int i = 0; i < 16; i++) step(1, 1, 10, 0);
        idle(TMO - 1);
        step(1, 1, 10, 0);
        chk("expiry_state",   int'(lock_state),   ST_LOCKED);
        chk("expiry_timeout", int'(timeout_flag), 0);

        // clear_stats coinciding with a timeout: the clear wins.
        idle(TMO - 1);
        step(1, 0, 0, 1);
        chk("tmo_clr_state",   int'(lock_state),   ST_IDLE);
        chk("tmo_clr_unl_ev",  int'(unlock_event), 1);
        chk("tmo_clr_slip",    int'(slip_count),   0);
        chk("tmo_clr_timeout", int'(timeout_flag), 0);

        // Asynchronous reset while in HOLD.
        for (int i = 0; i < 16; i++) step(1, 1, 10, 0);
        step(1, 1, 300, 0);
        chk("pre_rst_hold", int'(lock_state), ST_HOLD);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomized traffic, alternating clean and noisy regimes, with starvation bursts.
        for (int i = 0; i < 6000; i++) begin
            int pin;
            pin = ((i / 500) % 2 == 0) ? 97 : 65;
            if ($urandom_range(0, 1999) == 0) idle(TMO - 2 + int'($urandom_range(0, 3)));
            step($urandom_range(0, 99) < 92,
                 $urandom_range(0, 99) < 40,
                 rnd_err(pin),
                 $urandom_range(0, 99) < 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
